// File: rtl/signed_div.sv
// rtl/signed_div.sv - restoring shift-subtract divider, unsigned or two's complement
// One quotient bit per cycle; zero divisor short-circuits to a saturated result.
module signed_div #(
   parameter int A_WIDTH = 8,
   parameter int B_WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [A_WIDTH-1:0] dat_a,
   input  logic [B_WIDTH-1:0] dat_b,
   input  logic               tc,
   output logic [A_WIDTH-1:0] quotient,
   output logic [B_WIDTH-1:0] remainder,
   output logic               busy,
   output logic               done,
   output logic               div_zero
);

   localparam int CNT_W = $clog2(A_WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [A_WIDTH-1:0] dvd_q, dvd_d;
   logic [B_WIDTH-1:0] dvs_q, dvs_d;
   logic [B_WIDTH-1:0] prem_q, prem_d;
   logic               sa_q, sa_d;
   logic               sb_q, sb_d;
   logic               tc_q, tc_d;
   logic               zero_q, zero_d;
   logic [A_WIDTH-1:0] quo_q, quo_d;
   logic [B_WIDTH-1:0] rem_q, rem_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               dz_q, dz_d;

   logic [B_WIDTH:0]   r_sh;
   logic [B_WIDTH:0]   diff;
   logic               r_ge;
   logic [B_WIDTH-1:0] zrem;

   // Partial remainder stays below the divisor, so B bits suffice between steps.
   assign r_sh = {prem_q, dvd_q[A_WIDTH-1]};
   assign diff = r_sh - {1'b0, dvs_q};
   assign r_ge = ~diff[B_WIDTH];

   // Zero-divisor case keeps the raw dividend in dvd_q.
   generate
      if (A_WIDTH >= B_WIDTH) begin : g_zrem_slice
         assign zrem = dvd_q[B_WIDTH-1:0];
      end else begin : g_zrem_ext
         assign zrem = {{(B_WIDTH-A_WIDTH){1'b0}}, dvd_q};
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      prem_d  = prem_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      tc_d    = tc_q;
      zero_d  = zero_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      busy_d  = busy_q;
      dz_d    = dz_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               zero_d  = (dat_b == '0);
               sa_d    = tc & dat_a[A_WIDTH-1];
               sb_d    = tc & dat_b[B_WIDTH-1];
               tc_d    = tc;
               dvd_d   = (tc && dat_a[A_WIDTH-1] && dat_b != '0) ? -dat_a : dat_a;
               dvs_d   = (tc && dat_b[B_WIDTH-1]) ? -dat_b : dat_b;
               prem_d  = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = CALC;
            end
         end
         CALC: begin
            if (zero_q) begin
               quo_d   = '1;
               rem_d   = zrem;
               dz_d    = 1'b1;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               dvd_d  = {dvd_q[A_WIDTH-2:0], r_ge};
               prem_d = r_ge ? diff[B_WIDTH-1:0] : r_sh[B_WIDTH-1:0];
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(A_WIDTH - 1)) begin
                  state_d = FIN;
               end
            end
         end
         FIN: begin
            quo_d   = (tc_q && (sa_q != sb_q)) ? -dvd_q : dvd_q;
            rem_d   = (tc_q && sa_q) ? -prem_q : prem_q;
            dz_d    = 1'b0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         prem_q  <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         tc_q    <= 1'b0;
         zero_q  <= 1'b0;
         quo_q   <= '0;
         rem_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         prem_q  <= prem_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         tc_q    <= tc_d;
         zero_q  <= zero_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dz_q    <= dz_d;
      end
   end

   assign quotient  = quo_q;
   assign remainder = rem_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign div_zero  = dz_q;

endmodule

// File: tb/tb_signed_div.sv
// tb/tb_signed_div.sv - self-checking bench for signed_div against an integer model
module tb_signed_div;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] dat_a = '0;
   logic [7:0] dat_b = '0;
   logic       tc = 1'b0;
   logic [7:0] quotient;
   logic [7:0] remainder;
   logic       busy;
   logic       done;
   logic       div_zero;

   int checks = 0;
   int failures = 0;
   logic [7:0] prev_q, prev_r;

   signed_div #(.A_WIDTH(8), .B_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .dat_a(dat_a), .dat_b(dat_b), .tc(tc),
      .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
      .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Truncating integer division; zero divisor saturates the quotient.
   task automatic ref_div(input logic [7:0] a, input logic [7:0] b, input logic m,
                          output logic [7:0] q, output logic [7:0] r, output logic dz);
      int ia, ib, iq, ir;
      ia = m ? int'($signed(a)) : int'(a);
      ib = m ? int'($signed(b)) : int'(b);
      if (ib == 0) begin
         q = 8'hFF; r = a; dz = 1'b1;
      end else begin
         iq = ia / ib;
         ir = ia % ib;
         q = iq[7:0]; r = ir[7:0]; dz = 1'b0;
      end
   endtask

   task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic m);
      dat_a = a; dat_b = b; tc = m; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("busy_after_accept", busy, 1);
   endtask

   task automatic wait_done(input string tag, input int exp_lat,
                            input logic [7:0] a, input logic [7:0] b, input logic m);
      logic [7:0] eq, er;
      logic edz;
      int lat;
      ref_div(a, b, m, eq, er, edz);
      lat = 0;
      for (int n = 1; n <= 30; n++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = n;
            break;
         end
      end
      check({tag, "_latency"}, lat, exp_lat);
      if (lat != 0) begin
         check({tag, "_busy_low"}, busy, 0);
         check({tag, "_quotient"}, quotient, eq);
         check({tag, "_remainder"}, remainder, er);
         check({tag, "_div_zero"}, div_zero, edz);
         prev_q = eq;
         prev_r = er;
      end
   endtask

   task automatic run(input string tag, input logic [7:0] a, input logic [7:0] b, input logic m);
      @(negedge clk);
      launch(a, b, m);
      wait_done(tag, (b == 8'h00) ? 1 : 9, a, b, m);
   endtask

   initial begin
      int done_seen;
      logic [7:0] ra, rb;
      logic rm;

      #1;
      check("rst_quotient", quotient, 0);
      check("rst_remainder", remainder, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_div_zero", div_zero, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      run("u200_7", 8'd200, 8'd7, 1'b0);
      check("u200_7_q_value", quotient, 8'h1C);
      check("u200_7_r_value", remainder, 8'h04);
      run("s_m100_7", 8'h9C, 8'h07, 1'b1);
      check("s_m100_7_q_value", quotient, 8'hF2);
      check("s_m100_7_r_value", remainder, 8'hFE);
      run("s_100_m7", 8'd100, 8'hF9, 1'b1);
      run("s_m100_m7", 8'h9C, 8'hF9, 1'b1);
      run("zero_div", 8'h37, 8'h00, 1'b1);
      check("zero_div_q_value", quotient, 8'hFF);
      check("zero_div_r_value", remainder, 8'h37);
      run("ovf", 8'h80, 8'hFF, 1'b1);
      check("ovf_q_value", quotient, 8'h80);

      // Back-to-back: start issued inside the done cycle.
      launch(8'hC8, 8'h05, 1'b1);
      wait_done("b2b", 9, 8'hC8, 8'h05, 1'b1);

      // Start while busy is ignored; results hold during the computation.
      @(negedge clk);
      launch(8'd250, 8'd13, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      dat_a = 8'd3; dat_b = 8'd1; tc = 1'b1; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("hold_quotient", quotient, prev_q);
      check("hold_remainder", remainder, prev_r);
      wait_done("busy_ignore", 6, 8'd250, 8'd13, 1'b0);

      // Abort mid-operation with reset.
      @(negedge clk);
      launch(8'h9C, 8'h07, 1'b1);
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("abort_quotient", quotient, 0);
      check("abort_remainder", remainder, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_div_zero", div_zero, 0);
      @(negedge clk);
      rst = 1'b0;
      done_seen = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (done) done_seen++;
      end
      check("abort_no_done", done_seen, 0);
      run("after_rst", 8'd77, 8'd9, 1'b0);

      for (int i = 0; i < 150; i++) begin
         ra = 8'($urandom);
         rb = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
         rm = 1'($urandom);
         run($sformatf("rand%0d", i), ra, rb, rm);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
